// File: rtl/axi4_user_arbiter.sv
// Round-robin arbiter sharing the single-beat rd/wr command port of an AXI4 master controller
// among NUM_REQ requesters; one transaction outstanding, registered outputs throughout.
module axi4_user_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TO_CYCLES = 1024
) (
  input  logic                    m_aclk,
  input  logic                    m_arst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [31:0]             rsp_rdata,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    timeout,
  output logic [31:0]             rd_addr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  input  logic [31:0]             rd_data,
  output logic [31:0]             wr_addr,
  output logic [31:0]             wr_data,
  output logic                    wr_valid,
  input  logic                    wr_ready
);

  localparam int unsigned CntW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TO_CYCLES - 1);
  localparam logic [CntW-1:0] CntPrev = CntW'(TO_CYCLES - 2);

  typedef enum logic [1:0] {
    StIdle,
    StIssueRd,
    StIssueWr,
    StDone
  } state_e;

  state_e              state_q;
  logic [2:0]          ptr_q;
  logic [CntW-1:0]     wait_cnt_q;

  logic [NUM_REQ-1:0]  rot;
  logic                win;
  logic [2:0]          win_idx;
  logic [3:0]          sum;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_wdata;
  logic [2:0]          ptr_nxt;
  logic                ack;

  // Rotate requests so offset 0 is the pointer; the lowest set offset wins.
  always_comb begin
    rot     = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    win     = 1'b0;
    win_idx = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win && rot[k]) begin
        win = 1'b1;
        sum = {1'b0, ptr_q} + 4'(k);
        if (sum >= 4'(NUM_REQ)) begin
          sum = sum - 4'(NUM_REQ);
        end
        win_idx = sum[2:0];
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    ptr_nxt = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
    ack     = (state_q == StIssueRd) ? rd_ready : wr_ready;
  end

  always_ff @(posedge m_aclk) begin
    if (m_arst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      wait_cnt_q <= '0;
      req_done   <= '0;
      rsp_rdata  <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_valid   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win) begin
            grant_id   <= win_idx;
            busy       <= 1'b1;
            wait_cnt_q <= '0;
            if (sel_we) begin
              state_q  <= StIssueWr;
              wr_valid <= 1'b1;
              wr_addr  <= sel_addr;
              wr_data  <= sel_wdata;
            end else begin
              state_q  <= StIssueRd;
              rd_valid <= 1'b1;
              rd_addr  <= sel_addr;
            end
          end
        end
        StIssueRd, StIssueWr: begin
          // The wait never aborts; the timeout flag only reports a slow controller.
          if (wait_cnt_q != CntLast) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
          if (wait_cnt_q == CntPrev) begin
            timeout <= 1'b1;
          end
          if (ack) begin
            if (state_q == StIssueRd) begin
              rsp_rdata <= rd_data;
            end
            rd_valid <= 1'b0;
            wr_valid <= 1'b0;
            req_done <= NUM_REQ'(1) << grant_id;
            state_q  <= StDone;
          end
        end
        StDone: begin
          req_done <= '0;
          ptr_q    <= ptr_nxt;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_user_arbiter.sv
// Randomized bench for axi4_user_arbiter: the bench plays requesters and controller and checks
// every transaction against a transaction-level round-robin model.
module tb_axi4_user_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic              m_aclk = 1'b0;
  logic              m_arst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_we = '0;
  logic [32*N-1:0]   req_addr = '0;
  logic [32*N-1:0]   req_wdata = '0;
  logic [N-1:0]      req_done;
  logic [31:0]       rsp_rdata;
  logic [2:0]        grant_id;
  logic              busy;
  logic              timeout;
  logic [31:0]       rd_addr;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [31:0]       rd_data = '0;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic              wr_valid;
  logic              wr_ready = 1'b0;

  axi4_user_arbiter #(
    .NUM_REQ  (N),
    .TO_CYCLES(TO)
  ) dut (
    .m_aclk   (m_aclk),
    .m_arst   (m_arst),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_done (req_done),
    .rsp_rdata(rsp_rdata),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready)
  );

  always #5 m_aclk = ~m_aclk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: pending requests, round-robin pointer, sticky timeout, last read data.
  logic        p_valid[N];
  logic        p_we[N];
  logic [31:0] p_addr[N];
  logic [31:0] p_wdata[N];
  int unsigned m_ptr = 0;
  logic        m_to = 1'b0;
  logic [31:0] m_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = p_valid[i];
      req_we[i]             = p_we[i];
      req_addr[32*i +: 32]  = p_addr[i];
      req_wdata[32*i +: 32] = p_wdata[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int unsigned i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    p_valid[i] = 1'b1;
    p_we[i]    = we;
    p_addr[i]  = addr;
    p_wdata[i] = wdata;
  endtask

  // First pending requester at or above the pointer, wrapping.
  function automatic int unsigned pick();
    for (int k = 0; k < N; k++) begin
      int unsigned idx = (m_ptr + int'(k)) % N;
      if (p_valid[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic do_reset();
    m_arst = 1'b1;
    clear_reqs();
    drive_reqs();
    repeat (2) @(negedge m_aclk);
    m_arst  = 1'b0;
    m_ptr   = 0;
    m_to    = 1'b0;
    m_rdata = '0;
  endtask

  // Called at a negedge with the DUT idle and the requests just driven. Controller acks after
  // lat wait cycles. Returns at the negedge after the DUT is idle again.
  task automatic run_txn(input int unsigned lat, input logic [31:0] data);
    int unsigned g;
    g = pick();
    @(negedge m_aclk);
    check("grant_id", {29'b0, grant_id}, g);
    check("cmd_addr", p_we[g] ? wr_addr : rd_addr, p_addr[g]);
    if (p_we[g]) check("wr_data", wr_data, p_wdata[g]);
    for (int n = 1; n <= int'(lat) + 1; n++) begin
      if (n >= int'(TO)) m_to = 1'b1;
      check("rd_valid", {31'b0, rd_valid}, {31'b0, !p_we[g]});
      check("wr_valid", {31'b0, wr_valid}, {31'b0, p_we[g]});
      check("busy_issue", {31'b0, busy}, 1);
      check("timeout", {31'b0, timeout}, {31'b0, m_to});
      check("early_done", {28'b0, req_done}, 0);
      if (n == int'(lat) + 1) begin
        rd_ready = !p_we[g];
        wr_ready = p_we[g];
        rd_data  = data;
      end else begin
        rd_data = $urandom;
      end
      @(negedge m_aclk);
    end
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    rd_data  = $urandom;
    if (!p_we[g]) m_rdata = data;
    if (lat + 1 >= TO - 1) m_to = 1'b1;
    check("req_done", {28'b0, req_done}, 32'd1 << g);
    check("rsp_rdata", rsp_rdata, m_rdata);
    check("valid_drop", {30'b0, rd_valid, wr_valid}, 0);
    check("busy_done", {31'b0, busy}, 1);
    check("timeout_done", {31'b0, timeout}, {31'b0, m_to});
    p_valid[g] = 1'b0;
    m_ptr      = (g + 1) % N;
    drive_reqs();
    @(negedge m_aclk);
    check("done_pulse", {28'b0, req_done}, 0);
    check("busy_idle", {31'b0, busy}, 0);
    check("grant_hold", {29'b0, grant_id}, g);
  endtask

  initial begin
    int unsigned order[5];
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 1'b0;
      p_we[i]    = 1'b0;
      p_addr[i]  = '0;
      p_wdata[i] = '0;
    end

    // Reset state
    do_reset();
    @(negedge m_aclk);
    check("rst_done", {28'b0, req_done}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_grant", {29'b0, grant_id}, 0);
    check("rst_flags", {29'b0, busy, timeout, rd_valid}, 0);
    check("rst_wr_valid", {31'b0, wr_valid}, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    // Single read, ack 3 cycles after rd_valid
    set_req(1, 1'b0, 32'h100, 32'h0);
    drive_reqs();
    run_txn(3, 32'hDEAD_BEEF);

    // Single write
    set_req(2, 1'b1, 32'h200, 32'h55AA);
    drive_reqs();
    run_txn(2, $urandom);

    // All requesting continuously from reset, immediate ready
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom), $urandom, $urandom);
    drive_reqs();
    for (int k = 0; k < 5; k++) begin
      run_txn(0, $urandom);
      check("rr_order", {29'b0, grant_id}, order[k]);
      set_req(grant_id, 1'($urandom), $urandom, $urandom);
      drive_reqs();
    end

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 1'($urandom), $urandom, $urandom);
        end
        any |= p_valid[i];
      end
      if (!any) set_req($urandom_range(0, N - 1), 1'($urandom), $urandom, $urandom);
      drive_reqs();
      run_txn($urandom_range(0, 4), $urandom);
    end

    // Ready withheld past TO cycles, ack at cycle 20
    clear_reqs();
    set_req(1, 1'b0, 32'h0000_0400, 32'h0);
    drive_reqs();
    run_txn(19, 32'hCAFE_F00D);
    @(negedge m_aclk);
    check("timeout_sticky", {31'b0, timeout}, 1);

    // Reset pulsed while a write is outstanding
    set_req(3, 1'b1, 32'h0000_0300, 32'h1234_5678);
    drive_reqs();
    @(negedge m_aclk);
    check("pre_rst_wr_valid", {31'b0, wr_valid}, 1);
    @(negedge m_aclk);
    m_arst = 1'b1;
    clear_reqs();
    drive_reqs();
    @(negedge m_aclk);
    m_arst  = 1'b0;
    m_ptr   = 0;
    m_to    = 1'b0;
    m_rdata = '0;
    check("mid_rst_wr_valid", {31'b0, wr_valid}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_timeout", {31'b0, timeout}, 0);
    check("mid_rst_done", {28'b0, req_done}, 0);
    @(negedge m_aclk);
    check("post_rst_done", {28'b0, req_done}, 0);
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom), $urandom, $urandom);
    drive_reqs();
    run_txn(1, $urandom);
    check("ptr_after_reset", {29'b0, grant_id}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
